// File: rtl/instr_queue_pkg.sv
// Shared constants for the instruction queue: bus width, default depth,
// issue-FSM state encoding and the core's opcode values (used by stimulus).
package instr_queue_pkg;

    localparam int IQ_DATA_W = 32;
    localparam int IQ_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } issue_state_e;

    // Opcode field values understood by the coprocessor core; the queue itself never decodes them.
    localparam logic [3:0] OP_READ  = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_DET2  = 4'h5;
    localparam logic [3:0] OP_DET3  = 4'h6;
    localparam logic [3:0] OP_DET4  = 4'h7;
    localparam logic [3:0] OP_DET5  = 4'h8;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Host/core-facing signal bundle of the instruction queue.
// master = host PIO + core side, slave = the queue.
interface instr_queue_if #(
    parameter int DATA_W = instr_queue_pkg::IQ_DATA_W,
    parameter int CNT_W  = instr_queue_pkg::cnt_width(instr_queue_pkg::IQ_DEPTH)
);
    logic [DATA_W-1:0] host_instruction;
    logic              host_wr;
    logic              clear_overflow;
    logic              core_idle;
    logic [DATA_W-1:0] instruction;
    logic              activate_instruction;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              busy;

    modport master (
        output host_instruction, host_wr, clear_overflow, core_idle,
        input  instruction, activate_instruction, full, empty, count, overflow, busy
    );

    modport slave (
        input  host_instruction, host_wr, clear_overflow, core_idle,
        output instruction, activate_instruction, full, empty, count, overflow, busy
    );
endinterface

// File: rtl/instr_queue_sync_fifo.sv
// Circular-buffer FIFO with arithmetic occupancy counter; a push while full
// is accepted only when a pop happens in the same cycle.
module instr_queue_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_count   = r_count;
    // Head is read combinationally so the issuer can load it in its decision cycle.
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_queue.sv
// Host-to-core instruction buffer: edge-detected host pushes, sticky overflow,
// and an issue FSM that releases one word per core FETCH round trip.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DATA_W = IQ_DATA_W,
    parameter int DEPTH  = IQ_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    instr_queue_if.slave bus
);
    logic              r_host_wr_q;
    logic              w_wr_fire;
    logic              w_load;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_head;

    issue_state_e      r_state;
    issue_state_e      w_state_next;
    logic [DATA_W-1:0] r_instruction;
    logic              r_activate;
    logic              r_busy;
    logic              r_overflow;
    logic              w_activate_next;
    logic              w_busy_next;

    // The PIO holds host_wr as a level; only its rising edge counts as a push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_wr_q <= 1'b0;
        end else begin
            r_host_wr_q <= bus.host_wr;
        end
    end

    assign w_wr_fire = bus.host_wr & ~r_host_wr_q;

    instr_queue_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_fire),
        .i_pop   (w_load),
        .i_data  (bus.host_instruction),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (!w_empty && bus.core_idle) w_state_next = ST_ISSUE;
            ST_ISSUE:     w_state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!bus.core_idle) w_state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.core_idle) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // The pulse is registered, so it lands one cycle after ISSUE is entered.
    always_comb begin
        w_load          = (r_state == ST_IDLE) && !w_empty && bus.core_idle;
        w_activate_next = (r_state == ST_ISSUE);
        w_busy_next     = r_busy;
        if (w_load) begin
            w_busy_next = 1'b1;
        end else if ((r_state == ST_WAIT_DONE) && bus.core_idle) begin
            w_busy_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instruction <= '0;
            r_activate    <= 1'b0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_load) begin
                r_instruction <= w_head;
            end
            r_activate <= w_activate_next;
            r_busy     <= w_busy_next;
            // A drop in the same cycle as a clear must stay visible.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.instruction          = r_instruction;
    assign bus.activate_instruction = r_activate;
    assign bus.full                 = w_full;
    assign bus.empty                = w_empty;
    assign bus.count                = w_count;
    assign bus.overflow             = r_overflow;
    assign bus.busy                 = r_busy;

endmodule
